// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two request channels, the shared-ALU link and
// the response channel of alu_arbiter.
//   r0_* / r1_*  : request channels (valid, ready, a, b, sel)
//   alu_*        : registered operands out, combinational result back
//   rsp_*        : tagged response channel
// Modports: slave = the arbiter, master = requesters, ALU and consumer.
interface alu_arbiter_if;
  logic        r0_valid;
  logic        r0_ready;
  logic [31:0] r0_a;
  logic [31:0] r0_b;
  logic [2:0]  r0_sel;
  logic        r1_valid;
  logic        r1_ready;
  logic [31:0] r1_a;
  logic [31:0] r1_b;
  logic [2:0]  r1_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_offset;
  logic [31:0] rsp_address;
  logic        rsp_err;

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_sel,
    input  r1_valid, r1_a, r1_b, r1_sel,
    input  alu_result, rsp_ready,
    output r0_ready, r1_ready,
    output alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_id, rsp_result, rsp_offset, rsp_address, rsp_err
  );

  modport master (
    output r0_valid, r0_a, r0_b, r0_sel,
    output r1_valid, r1_a, r1_b, r1_sel,
    output alu_result, rsp_ready,
    input  r0_ready, r1_ready,
    input  alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_id, rsp_result, rsp_offset, rsp_address, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute stage
// (requester 0) and the load/store address generator (requester 1).
// One operation is in flight at a time: IDLE (arbitrate) -> EXEC (ALU runs
// on registered operands) -> RESP (hold the response until taken).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : alu_arbiter_if.slave (requests, ALU link, response)
//   cnt0, cnt1  : saturating accepted-request counters
//   dbg_state   : current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high. A requester keeps its operands stable while
// valid=1 and ready=0; ready never depends on the same channel's operands.
module alu_arbiter #(
  parameter int CNT_W      = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   owner;
  logic   grant0;
  logic   grant1;
  logic   take;
  logic   sel_legal;

  // Contention goes to the requester that did not win last time, unless the
  // fixed-priority build is selected.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.r0_valid && bus.r1_valid) begin
      if (FIXED_PRIO != 0) grant0 = 1'b1;
      else                 grant0 = last_grant;
      grant1 = !grant0;
    end else begin
      grant0 = bus.r0_valid;
      grant1 = bus.r1_valid;
    end
  end

  assign bus.r0_ready = (state == IDLE) && grant0;
  assign bus.r1_ready = (state == IDLE) && grant1;
  assign take         = bus.r0_ready || bus.r1_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Codes 110 and 111 have no ALU function.
  assign sel_legal = !(bus.alu_sel[2] && bus.alu_sel[1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant     <= 1'b1;
      owner          <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_sel    <= '0;
      bus.rsp_result <= '0;
      bus.rsp_err    <= 1'b0;
      cnt0           <= '0;
      cnt1           <= '0;
    end else begin
      if (take) begin
        last_grant  <= grant1;
        owner       <= grant1;
        bus.alu_a   <= grant1 ? bus.r1_a   : bus.r0_a;
        bus.alu_b   <= grant1 ? bus.r1_b   : bus.r0_b;
        bus.alu_sel <= grant1 ? bus.r1_sel : bus.r0_sel;
        if (grant0 && (cnt0 != CNT_MAX)) cnt0 <= cnt0 + CNT_W'(1);
        if (grant1 && (cnt1 != CNT_MAX)) cnt1 <= cnt1 + CNT_W'(1);
      end
      if (state == EXEC) begin
        bus.rsp_result <= sel_legal ? bus.alu_result : 32'd0;
        bus.rsp_err    <= !sel_legal;
      end
    end
  end

  // owner only changes on a handshake, which cannot happen in RESP, so the
  // response tag is stable for as long as rsp_valid is high.
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_id      = owner;
  assign bus.rsp_offset  = bus.rsp_result[1:0];
  assign bus.rsp_address = {bus.rsp_result[31:2], 2'b00};
  assign dbg_state       = state;

endmodule
